// File: rtl/serial_bit_rev_deser_pkg.sv
// Shared types for the serial bit-order deserializer.
// The receiver FSM either collects bits or holds one finished word.
package serial_deser_pkg;

  typedef enum logic {
    RECV = 1'b0,
    HOLD = 1'b1
  } deser_state_t;

endpackage

// File: rtl/serial_bit_rev_deser_bit_rev.sv
// Purely combinational NBITS-wide bit reverser: data_o[i] = data_i[NBITS-1-i].
module bit_rev_nb #(
  parameter int NBITS = 8
) (
  input  logic [NBITS-1:0] data_i,
  output logic [NBITS-1:0] data_o
);

  for (genvar gi = 0; gi < NBITS; gi++) begin : g_rev
    assign data_o[gi] = data_i[NBITS-1-gi];
  end

endmodule

// File: rtl/serial_bit_rev_deser.sv
// Serial-to-parallel receiver: one bit per handshake, NBITS-bit words out
// through a single holding register, in LSB-first or MSB-first wire order.
module serial_bit_rev_deser
  import serial_deser_pkg::*;
#(
  parameter int NBITS = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_val,
  output logic             in_rdy,
  input  logic             in_bit,
  input  logic             msb_first,
  output logic             out_val,
  input  logic             out_rdy,
  output logic [NBITS-1:0] out_msg
);

  localparam int CW = $clog2(NBITS + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(NBITS - 1);

  deser_state_t     state_q;
  logic [CW-1:0]    count_q;
  logic [NBITS-1:0] sreg_q;
  logic             order_q;
  logic             out_val_q;
  logic [NBITS-1:0] out_msg_q;

  logic [NBITS-1:0] sreg_d;
  logic [NBITS-1:0] sreg_rev;
  logic             bit_fire;

  // New bits enter at the MSB, so after NBITS shifts the first bit sits at [0].
  assign sreg_d   = {in_bit, sreg_q[NBITS-1:1]};
  assign in_rdy   = (state_q == RECV) || (state_q == HOLD && out_rdy);
  assign bit_fire = in_val && in_rdy;
  assign out_val  = out_val_q;
  assign out_msg  = out_msg_q;

  bit_rev_nb #(
    .NBITS (NBITS)
  ) u_bit_rev (
    .data_i (sreg_d),
    .data_o (sreg_rev)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= RECV;
      count_q   <= '0;
      sreg_q    <= '0;
      order_q   <= 1'b0;
      out_val_q <= 1'b0;
      out_msg_q <= '0;
    end else begin
      case (state_q)
        RECV: begin
          if (bit_fire) begin
            sreg_q <= sreg_d;
            if (count_q == '0) begin
              order_q <= msb_first;
            end
            if (count_q == LAST_IDX) begin
              count_q   <= '0;
              state_q   <= HOLD;
              out_val_q <= 1'b1;
              out_msg_q <= order_q ? sreg_rev : sreg_d;
            end else begin
              count_q <= count_q + 1'b1;
            end
          end
        end
        HOLD: begin
          // Draining and accepting the next word's first bit share one cycle.
          if (out_rdy) begin
            state_q   <= RECV;
            out_val_q <= 1'b0;
            if (in_val) begin
              sreg_q  <= sreg_d;
              order_q <= msb_first;
              count_q <= CW'(1);
            end else begin
              count_q <= '0;
            end
          end
        end
        default: begin
          state_q <= RECV;
          count_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_bit_rev_deser.sv
// Self-checking bench: directed scenarios plus random traffic, checked against
// a word-level model that collects wire bits and assembles them by bit order.
module tb_serial_bit_rev_deser;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         in_val;
  logic         in_rdy;
  logic         in_bit;
  logic         msb_first;
  logic         out_val;
  logic         out_rdy;
  logic [N-1:0] out_msg;

  int tests = 0;
  int fails = 0;

  // Reference model state: a pending word, the bits of the word in progress.
  bit           m_hold;
  logic [N-1:0] m_msg;
  bit           m_bits[$];
  bit           m_order;

  serial_bit_rev_deser #(.NBITS(N)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_val    (in_val),
    .in_rdy    (in_rdy),
    .in_bit    (in_bit),
    .msb_first (msb_first),
    .out_val   (out_val),
    .out_rdy   (out_rdy),
    .out_msg   (out_msg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Word value from wire bits: LSB-first puts bit k at weight 2^k,
  // MSB-first puts bit k at weight 2^(N-1-k).
  function automatic logic [N-1:0] assemble(input bit order);
    int unsigned w;
    w = 0;
    for (int k = 0; k < N; k++) begin
      if (m_bits[k]) w += order ? (1 << (N - 1 - k)) : (1 << k);
    end
    return w[N-1:0];
  endfunction

  task automatic model_reset();
    m_hold  = 1'b0;
    m_msg   = '0;
    m_order = 1'b0;
    m_bits.delete();
  endtask

  // One clock cycle: drive, check ready, advance model on the edge, check outputs.
  task automatic step(input logic v, input logic b, input logic m, input logic r);
    bit fire;
    in_val    = v;
    in_bit    = b;
    msb_first = m;
    out_rdy   = r;
    #2;
    chk("in_rdy", in_rdy, (!m_hold) || r);
    fire = v && ((!m_hold) || r);
    @(posedge clk);
    if (m_hold && r) begin
      m_hold = 1'b0;
      $display("[TB] word drained 0x%02h", m_msg);
    end
    if (fire) begin
      if (m_bits.size() == 0) m_order = m;
      m_bits.push_back(b);
      if (m_bits.size() == N) begin
        m_msg  = assemble(m_order);
        m_hold = 1'b1;
        m_bits.delete();
        $display("[TB] word done 0x%02h msb_first=%0d", m_msg, m_order);
      end
    end
    #1;
    chk("out_val", out_val, m_hold);
    chk("out_msg", out_msg, m_msg);
  endtask

  // Sends N bits in wire order wire_bits[0], wire_bits[1], ...; optional
  // idle gaps between bits and an msb_first flip after bit index flip_after.
  task automatic send_word(input logic [N-1:0] wire_bits, input logic m, input logic r,
                           input int gap, input int flip_after);
    logic mm;
    for (int k = 0; k < N; k++) begin
      mm = (k > flip_after) ? !m : m;
      step(1'b1, wire_bits[k], mm, r);
      if (k < N - 1) begin
        for (int g = 0; g < gap; g++) step(1'b0, 1'($urandom), mm, r);
      end
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_out_val", out_val, 0);
    chk("rst_out_msg", out_msg, 0);
    chk("rst_in_rdy", in_rdy, 1);
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  logic [N-1:0] w;

  initial begin
    reset_n   = 1'b1;
    in_val    = 1'b0;
    in_bit    = 1'b0;
    msb_first = 1'b0;
    out_rdy   = 1'b0;
    model_reset();
    #3;
    do_reset();

    // LSB-first single set bit, then MSB-first of the same sequence.
    send_word(8'h01, 1'b0, 1'b1, 0, N);
    chk("t1_val", out_val, 1);
    chk("t1_msg", out_msg, 8'h01);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    send_word(8'h01, 1'b1, 1'b1, 0, N);
    chk("t2_msb_msg", out_msg, 8'h80);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    w = 8'b0100_1011; // wire 1,1,0,1,0,0,1,0
    send_word(w, 1'b0, 1'b1, 0, N);
    chk("t2_lsb_msg", out_msg, 8'h4B);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Backpressure holds the word stable and blocks input.
    send_word(8'h3C, 1'b0, 1'b0, 0, N);
    for (int c = 0; c < 3; c++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      chk("t3_hold_val", out_val, 1);
      chk("t3_hold_msg", out_msg, 8'h3C);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t3_drained", out_val, 0);

    // Back-to-back words with continuous in_val.
    send_word(8'h12, 1'b0, 1'b1, 0, N);
    chk("t4_w0", out_msg, 8'h12);
    send_word(8'h34, 1'b0, 1'b1, 0, N);
    chk("t4_w1_val", out_val, 1);
    chk("t4_w1", out_msg, 8'h34);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Gaps and a mid-word order change: MSB-first latched at bit 0.
    w = 8'b1010_0101; // 0xA5 reversed onto the wire
    send_word(w, 1'b1, 1'b1, 2, 3);
    chk("t5_msg", out_msg, 8'hA5);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Reset mid-word discards the partial word.
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    do_reset();
    send_word(8'hFF, 1'b0, 1'b1, 0, N);
    chk("t6_msg", out_msg, 8'hFF);

    // Reset while a word is held drops out_val at once.
    send_word(8'h5A, 1'b1, 1'b0, 0, N);
    chk("t6_hold_val", out_val, 1);
    do_reset();

    // Random traffic against the model.
    for (int c = 0; c < 600; c++) begin
      step(1'($urandom_range(0, 9) < 7), 1'($urandom), 1'($urandom),
           1'($urandom_range(0, 9) < 6));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
